next_addr_ctrl: RTL

Next-address control stage for the Am2909 microprogram sequencer. It holds the current microinstruction's next-address field in a pipeline register and decodes a 4-bit next-address opcode against a condition input. It drives the sequencer's S, FE, PUP, ZERO and D inputs. It also owns a loop counter for repeat and loop instructions. It sits directly upstream of Am2909 and is fed by microprogram memory and the condition-code mux.

---
 rtl/next_addr_ctrl_pkg.sv | 31 +++
 rtl/next_addr_ctrl_loop_counter.sv | 27 ++
 rtl/next_addr_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/next_addr_ctrl_pkg.sv
// Shared Am2900-family definitions: next-address opcodes, sequencer source
// selects and the condition-pass helper used by the next-address decoder.
package next_addr_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CJS  = 4'd1,
    OP_JMAP = 4'd2,
    OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,
    OP_RFCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_CRTN = 4'd10,
    OP_CJPP = 4'd11,
    OP_LDCT = 4'd12,
    OP_LOOP = 4'd13
  } opcode_e;

  typedef enum logic [1:0] {
    SEL_UPC  = 2'b00,
    SEL_AR   = 2'b01,
    SEL_STK0 = 2'b10,
    SEL_D    = 2'b11
  } sel_e;

  // A disabled condition always passes.
  function automatic logic cond_pass(input logic cc, input logic ccen);
    return !ccen || cc;
  endfunction

endpackage

// File: rtl/next_addr_ctrl_loop_counter.sv
// Loop counter for repeat/loop microinstructions: loads a count and
// decrements toward zero without ever wrapping.
module next_addr_ctrl_loop_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CP,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_zero
);

  assign is_zero = (count == '0);

  always_ff @(posedge CP or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !is_zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/next_addr_ctrl.sv
// Next-address control stage for an Am2909 sequencer: pipeline register for
// the next-address field plus a single combinational opcode/condition decode.
module next_addr_ctrl
  import next_addr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CP,
  input  logic             RESET,
  input  logic             PL_EN,
  input  logic [3:0]       I,
  input  logic [WIDTH-1:0] BA,
  input  logic [WIDTH-1:0] MAP,
  input  logic             CC,
  input  logic             CCEN,
  output logic [1:0]       S,
  output logic             FE,
  output logic             PUP,
  output logic             ZERO,
  output logic [WIDTH-1:0] D,
  output logic             CNT_ZERO
);

  opcode_e          pipe_i_p0;
  logic [WIDTH-1:0] pipe_ba_p0;
  logic [WIDTH-1:0] ctr_count;
  logic             ctr_load;
  logic             ctr_dec;
  logic             use_map;
  logic             pass;
  sel_e             s_sel;

  // Stage p0: pipeline register; reset leaves JZ so the sequencer restarts at 0.
  always_ff @(posedge CP or negedge RESET) begin
    if (!RESET) begin
      pipe_i_p0  <= OP_JZ;
      pipe_ba_p0 <= '0;
    end else if (PL_EN) begin
      pipe_i_p0  <= opcode_e'(I);
      pipe_ba_p0 <= BA;
    end
  end

  next_addr_ctrl_loop_counter #(.WIDTH(WIDTH)) u_ctr (
    .CP      (CP),
    .RESET   (RESET),
    .load    (ctr_load),
    .load_val(pipe_ba_p0),
    .dec     (ctr_dec),
    .count   (ctr_count),
    .is_zero (CNT_ZERO)
  );

  assign pass = cond_pass(CC, CCEN);

  always_comb begin
    s_sel    = SEL_UPC;
    FE       = 1'b1;
    PUP      = 1'b1;
    ZERO     = 1'b1;
    use_map  = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    case (pipe_i_p0)
      OP_JZ: begin
        ZERO  = 1'b0;
        s_sel = SEL_D;
      end
      OP_CJS: begin
        if (pass) begin
          s_sel = SEL_D;
          FE    = 1'b0;
        end
      end
      OP_JMAP: begin
        s_sel   = SEL_D;
        use_map = 1'b1;
      end
      OP_CJP: begin
        if (pass) s_sel = SEL_D;
      end
      OP_PUSH: begin
        FE       = 1'b0;
        ctr_load = pass;
      end
      OP_RFCT: begin
        if (!CNT_ZERO) begin
          s_sel   = SEL_STK0;
          ctr_dec = 1'b1;
        end else begin
          FE  = 1'b0;
          PUP = 1'b0;
        end
      end
      OP_RPCT: begin
        if (!CNT_ZERO) begin
          s_sel   = SEL_D;
          ctr_dec = 1'b1;
        end
      end
      OP_CRTN: begin
        if (pass) begin
          s_sel = SEL_STK0;
          FE    = 1'b0;
          PUP   = 1'b0;
        end
      end
      OP_CJPP: begin
        if (pass) begin
          s_sel = SEL_D;
          FE    = 1'b0;
          PUP   = 1'b0;
        end
      end
      OP_LDCT: ctr_load = 1'b1;
      OP_LOOP: begin
        if (!pass) begin
          s_sel = SEL_STK0;
        end else begin
          FE  = 1'b0;
          PUP = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign S = s_sel;
  assign D = use_map ? MAP : pipe_ba_p0;

endmodule
